// File: rtl/wordle_pkg.sv
// rtl/wordle_pkg.sv - shared states, ASCII codes and default sizes for the Wordle guess controller
package wordle_pkg;

  localparam logic [3:0] QI    = 4'b0001;
  localparam logic [3:0] QRUN  = 4'b0010;
  localparam logic [3:0] QEVAL = 4'b0100;
  localparam logic [3:0] QDONE = 4'b1000;

  typedef enum logic [3:0] {
    S_I    = QI,
    S_RUN  = QRUN,
    S_EVAL = QEVAL,
    S_DONE = QDONE
  } state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_Z     = 8'h5A;

  localparam int WORD_LEN_DEF    = 5;
  localparam int MAX_GUESSES_DEF = 6;

  function automatic logic is_upper_letter(input logic [7:0] c);
    return (c >= ASCII_A) && (c <= ASCII_Z);
  endfunction

endpackage

// File: rtl/wordle_guess_buf.sv
// rtl/wordle_guess_buf.sv - fixed-depth letter buffer with push, pop-last and clear-to-space
module wordle_guess_buf
  import wordle_pkg::*;
#(
  parameter int WORD_LEN = WORD_LEN_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [7:0]            i_data,
  output logic [8*WORD_LEN-1:0] o_guess,
  output logic [2:0]            o_count
);

  localparam logic [2:0] LEN = 3'(WORD_LEN);

  logic [7:0] r_slots [WORD_LEN];
  logic [2:0] r_count;
  logic       w_can_push;
  logic       w_can_pop;
  logic [2:0] w_last;

  assign w_can_push = i_push && (r_count < LEN);
  assign w_can_pop  = i_pop && (r_count != 3'd0);
  assign w_last     = r_count - 3'd1;

  // Clear beats pop beats push; the controller normally asserts only one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= 3'd0;
      for (int i = 0; i < WORD_LEN; i++) r_slots[i] <= ASCII_SPACE;
    end else if (i_clr) begin
      r_count <= 3'd0;
      for (int i = 0; i < WORD_LEN; i++) r_slots[i] <= ASCII_SPACE;
    end else if (w_can_pop) begin
      r_count <= w_last;
      for (int i = 0; i < WORD_LEN; i++)
        if (w_last == 3'(i)) r_slots[i] <= ASCII_SPACE;
    end else if (w_can_push) begin
      r_count <= r_count + 3'd1;
      for (int i = 0; i < WORD_LEN; i++)
        if (r_count == 3'(i)) r_slots[i] <= i_data;
    end
  end

  for (genvar g = 0; g < WORD_LEN; g++) begin : g_pack
    assign o_guess[8*g +: 8] = r_slots[g];
  end

  assign o_count = r_count;

endmodule

// File: rtl/wordle_guess_ctrl.sv
// rtl/wordle_guess_ctrl.sv - one-game Wordle sequencer: letter entry, evaluator handshake, win/lose
module wordle_guess_ctrl
  import wordle_pkg::*;
#(
  parameter int WORD_LEN    = WORD_LEN_DEF,
  parameter int MAX_GUESSES = MAX_GUESSES_DEF
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic                  Ack,
  input  logic                  sel,
  input  logic                  del,
  input  logic                  enter,
  input  logic [7:0]            curr_letter,
  input  logic                  eval_ack,
  input  logic                  eval_win,
  output logic [8*WORD_LEN-1:0] guess,
  output logic [2:0]            letter_count,
  output logic [2:0]            attempt,
  output logic                  eval_req,
  output logic                  done,
  output logic                  win,
  output logic                  lose,
  output logic                  q_I,
  output logic                  q_Run,
  output logic                  q_Eval,
  output logic                  q_Done
);

  localparam logic [2:0] LEN  = 3'(WORD_LEN);
  localparam logic [2:0] LAST = 3'(MAX_GUESSES);

  state_e     r_state;
  logic [2:0] r_attempt;
  logic       r_eval_req;
  logic       r_win;
  logic       r_lose;

  state_e     w_next_state;
  logic [2:0] w_attempt_nx;
  logic       w_eval_req_nx;
  logic       w_win_nx;
  logic       w_lose_nx;
  logic       w_clr;
  logic       w_push;
  logic       w_pop;
  logic [2:0] w_count;
  logic [2:0] w_attempt_inc;

  assign w_attempt_inc = r_attempt + 3'd1;

  wordle_guess_buf #(.WORD_LEN(WORD_LEN)) u_buf (
    .i_clk   (Clk),
    .i_rst_n (reset),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (curr_letter),
    .o_guess (guess),
    .o_count (w_count)
  );

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_I;
      r_attempt  <= 3'd0;
      r_eval_req <= 1'b0;
      r_win      <= 1'b0;
      r_lose     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_attempt  <= w_attempt_nx;
      r_eval_req <= w_eval_req_nx;
      r_win      <= w_win_nx;
      r_lose     <= w_lose_nx;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_attempt_nx  = r_attempt;
    w_eval_req_nx = r_eval_req;
    w_win_nx      = r_win;
    w_lose_nx     = r_lose;
    w_clr         = 1'b0;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    case (r_state)
      S_I: begin
        w_eval_req_nx = 1'b0;
        if (Start) begin
          w_next_state = S_RUN;
          w_clr        = 1'b1;
          w_attempt_nx = 3'd0;
          w_win_nx     = 1'b0;
          w_lose_nx    = 1'b0;
        end
      end
      S_RUN: begin
        // enter owns the cycle even when the guess is short, so del/sel are dropped too
        if (enter) begin
          if (w_count == LEN) begin
            w_next_state  = S_EVAL;
            w_eval_req_nx = 1'b1;
          end
        end else if (del) begin
          w_pop = (w_count != 3'd0);
        end else if (sel) begin
          w_push = (w_count < LEN) && is_upper_letter(curr_letter);
        end
      end
      S_EVAL: begin
        w_eval_req_nx = 1'b1;
        if (eval_ack) begin
          w_eval_req_nx = 1'b0;
          w_attempt_nx  = w_attempt_inc;
          if (eval_win) begin
            w_next_state = S_DONE;
            w_win_nx     = 1'b1;
          end else if (w_attempt_inc == LAST) begin
            w_next_state = S_DONE;
            w_lose_nx    = 1'b1;
          end else begin
            w_next_state = S_RUN;
            w_clr        = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (Ack) w_next_state = S_I;
      end
      default: begin
        w_next_state  = S_I;
        w_eval_req_nx = 1'b0;
      end
    endcase
  end

  assign letter_count = w_count;
  assign attempt      = r_attempt;
  assign eval_req     = r_eval_req;
  assign win          = r_win;
  assign lose         = r_lose;
  assign done         = (r_state == S_DONE);
  assign q_I          = (r_state == S_I);
  assign q_Run        = (r_state == S_RUN);
  assign q_Eval       = (r_state == S_EVAL);
  assign q_Done       = (r_state == S_DONE);

endmodule

// File: tb/tb_wordle_guess_ctrl.sv
// tb/tb_wordle_guess_ctrl.sv - directed self-checking bench for wordle_guess_ctrl
module tb_wordle_guess_ctrl;

  logic        Clk = 1'b0;
  logic        reset;
  logic        Start, Ack, sel, del, enter;
  logic [7:0]  curr_letter;
  logic        eval_ack, eval_win;
  logic [39:0] guess;
  logic [2:0]  letter_count, attempt;
  logic        eval_req, done, win, lose;
  logic        q_I, q_Run, q_Eval, q_Done;

  int checks   = 0;
  int failures = 0;

  localparam logic [39:0] SPACES = 40'h2020202020;
  localparam logic [39:0] CRANE  = 40'h454E415243;

  always #5 Clk = ~Clk;

  wordle_guess_ctrl dut (
    .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack),
    .sel(sel), .del(del), .enter(enter), .curr_letter(curr_letter),
    .eval_ack(eval_ack), .eval_win(eval_win),
    .guess(guess), .letter_count(letter_count), .attempt(attempt),
    .eval_req(eval_req), .done(done), .win(win), .lose(lose),
    .q_I(q_I), .q_Run(q_Run), .q_Eval(q_Eval), .q_Done(q_Done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_sel(input logic [7:0] c);
    sel = 1'b1; curr_letter = c;
    step();
    sel = 1'b0;
  endtask

  task automatic do_del();
    del = 1'b1;
    step();
    del = 1'b0;
  endtask

  task automatic do_enter();
    enter = 1'b1;
    step();
    enter = 1'b0;
  endtask

  task automatic do_eval(input logic w);
    eval_ack = 1'b1; eval_win = w;
    step();
    eval_ack = 1'b0; eval_win = 1'b0;
  endtask

  task automatic fill(input logic [39:0] word);
    for (int i = 0; i < 5; i++) do_sel(word[8*i +: 8]);
  endtask

  initial begin
    reset = 1'b0; Start = 0; Ack = 0; sel = 0; del = 0; enter = 0;
    curr_letter = 8'h00; eval_ack = 0; eval_win = 0;
    step(); step();
    chk("rst_state", {q_Done, q_Eval, q_Run, q_I}, 4'b0001);
    chk("rst_guess", guess, SPACES);
    chk("rst_count", letter_count, 0);
    chk("rst_outs", {attempt, eval_req, done, win, lose}, 0);
    reset = 1'b1;
    step();

    Start = 1'b1; step(); Start = 1'b0;
    chk("start_run", q_Run, 1);
    fill(CRANE);
    do_sel(8'h58);
    chk("crane_guess", guess, CRANE);
    chk("crane_count", letter_count, 5);
    do_enter();
    chk("enter_req", {q_Eval, eval_req}, 2'b11);

    // reset in the middle of an evaluation, then a stale ack
    reset = 1'b0; step(); reset = 1'b1;
    chk("midrst_state", {q_Done, q_Eval, q_Run, q_I}, 4'b0001);
    chk("midrst_vals", {attempt, eval_req}, 0);
    chk("midrst_guess", guess, SPACES);
    do_eval(1'b1);
    chk("late_ack_state", {q_Done, q_Eval, q_Run, q_I}, 4'b0001);
    chk("late_ack_vals", {attempt, eval_req, win, lose}, 0);

    Start = 1'b1; step(); Start = 1'b0;
    do_sel(8'h43); do_sel(8'h52); do_sel(8'h41);
    chk("cra_count", letter_count, 3);
    chk("cra_guess", guess, 40'h2020415243);
    do_del(); do_del(); do_del(); do_del();
    chk("del_count", letter_count, 0);
    chk("del_guess", guess, SPACES);
    do_sel(8'h43); do_sel(8'h52); do_sel(8'h41); do_sel(8'h4E);
    do_enter();
    chk("short_enter", {q_Run, eval_req, letter_count}, {1'b1, 1'b0, 3'd4});
    do_sel(8'h45);
    enter = 1'b1; del = 1'b1; sel = 1'b1; curr_letter = 8'h5A;
    step();
    enter = 1'b0; del = 1'b0; sel = 1'b0;
    chk("prio_eval", {q_Eval, eval_req}, 2'b11);
    chk("prio_guess", guess, CRANE);
    chk("prio_count", letter_count, 5);
    sel = 1'b1; del = 1'b1; enter = 1'b1; curr_letter = 8'h41;
    step();
    sel = 1'b0; del = 1'b0; enter = 1'b0;
    chk("eval_frozen", guess, CRANE);
    do_eval(1'b0);
    chk("miss1_state", {q_Run, eval_req, attempt}, {1'b1, 1'b0, 3'd1});
    chk("miss1_clear", {guess, letter_count}, {SPACES, 3'd0});

    do_sel(8'h41); do_sel(8'h42);
    del = 1'b1; sel = 1'b1; curr_letter = 8'h5A;
    step();
    del = 1'b0; sel = 1'b0;
    chk("delsel_count", letter_count, 1);
    chk("delsel_guess", guess, 40'h2020202041);
    do_sel(8'h00);
    do_sel(8'h5B);
    do_sel(8'h40);
    chk("nonletter", letter_count, 1);
    do_sel(8'h5A);
    chk("z_accept", guess, 40'h2020205A41);

    // finish guess 2 and then miss through guess 6
    do_sel(8'h41); do_sel(8'h42); do_sel(8'h43);
    for (int g = 2; g <= 6; g++) begin
      if (g > 2) fill(CRANE);
      do_enter();
      do_eval(1'b0);
      if (g < 6) chk("miss_run", {q_Run, attempt}, {1'b1, 3'(g)});
    end
    chk("lose_state", {q_Done, done, lose, win}, 4'b1110);
    chk("lose_attempt", attempt, 6);
    Ack = 1'b1; step(); Ack = 1'b0;
    chk("lose_ack", {q_I, lose, win}, 3'b110);

    Start = 1'b1; step(); Start = 1'b0;
    chk("restart", {q_Run, attempt, win, lose}, {1'b1, 3'd0, 2'b00});
    for (int g = 0; g < 2; g++) begin
      fill(CRANE); do_enter(); do_eval(1'b0);
    end
    fill(CRANE);
    do_enter();
    begin
      int high = 0;
      for (int k = 0; k < 10; k++) begin
        step();
        if (eval_req) high++;
      end
      chk("req_held10", high, 10);
    end
    do_eval(1'b1);
    chk("win_state", {q_Done, done, win, lose, eval_req}, 5'b11100);
    chk("win_attempt", attempt, 3);
    chk("win_guess", guess, CRANE);
    do_sel(8'h41); do_del(); do_enter();
    chk("done_hold", {guess, attempt, q_Done}, {CRANE, 3'd3, 1'b1});
    Ack = 1'b1; step(); Ack = 1'b0;
    chk("win_ack", {q_I, done, win, lose}, 4'b1010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
